// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg: shared widths, ALU op encodings and EX-register action selection for the ID->EX stage.
package id_ex_pipe_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int ALUOP_W_DEF = 8;
    localparam int PERF_W_DEF  = 16;
    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_ADD = 8'h01;
    localparam logic [7:0] ALU_OR  = 8'h02;
    typedef enum logic [2:0] {ACT_HOLD, ACT_FLUSH, ACT_BUBBLE, ACT_LOAD, ACT_IDLE} act_e;
    // Priority: downstream stall > flush > load-use bubble > load > idle.
    function automatic act_e sel_act(input logic stall, input logic flush, input logic hazard, input logic valid);
        return stall ? ACT_HOLD : flush ? ACT_FLUSH : hazard ? ACT_BUBBLE : valid ? ACT_LOAD : ACT_IDLE;
    endfunction
endpackage

// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: ID-side inputs, stall/flush controls and EX-side outputs of the ID->EX register.
//   master: drives id_*, stall_i, flush_i; observes stall_o, ex_*, bubble_cnt_o
//   slave:  the pipeline register itself
interface id_ex_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 8,
    parameter int PERF_W  = 16
);
    logic               id_valid_i, id_branch_i, id_memread_i, id_memtoreg_i;
    logic               id_memwrite_i, id_alusrc_i, id_regwrite_i;
    logic [ALUOP_W-1:0] id_aluop_i;
    logic               id_read1_e_i, id_read2_e_i;
    logic [RADDR_W-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic [DATA_W-1:0]  id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i;
    logic               stall_i, flush_i, stall_o;
    logic               ex_valid_o, ex_branch_o, ex_memread_o, ex_memtoreg_o;
    logic               ex_memwrite_o, ex_alusrc_o, ex_regwrite_o;
    logic [ALUOP_W-1:0] ex_aluop_o;
    logic [RADDR_W-1:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [DATA_W-1:0]  ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o;
    logic [PERF_W-1:0]  bubble_cnt_o;
    modport master (
        output id_valid_i, id_branch_i, id_memread_i, id_memtoreg_i, id_memwrite_i, id_alusrc_i,
               id_regwrite_i, id_aluop_i, id_read1_e_i, id_read2_e_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i, stall_i, flush_i,
        input  stall_o, ex_valid_o, ex_branch_o, ex_memread_o, ex_memtoreg_o, ex_memwrite_o,
               ex_alusrc_o, ex_regwrite_o, ex_aluop_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
               ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o, bubble_cnt_o
    );
    modport slave (
        input  id_valid_i, id_branch_i, id_memread_i, id_memtoreg_i, id_memwrite_i, id_alusrc_i,
               id_regwrite_i, id_aluop_i, id_read1_e_i, id_read2_e_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i, stall_i, flush_i,
        output stall_o, ex_valid_o, ex_branch_o, ex_memread_o, ex_memtoreg_o, ex_memwrite_o,
               ex_alusrc_o, ex_regwrite_o, ex_aluop_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
               ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_pipe_hazard_detect.sv
// id_ex_pipe_hazard_detect: combinational load-use detection between the EX load and the ID instruction.
//   inputs:  EX valid/memread/rd, ID valid, per-operand read enables and addresses, stall_i, flush_i
//   outputs: hazard_o (raw load-use), stall_o (hold PC and IF/ID)
module id_ex_pipe_hazard_detect #(
    parameter int RADDR_W = 5
) (
    input  logic               ex_valid_i,
    input  logic               ex_memread_i,
    input  logic [RADDR_W-1:0] ex_rd_i,
    input  logic               id_valid_i,
    input  logic               id_read1_e_i,
    input  logic               id_read2_e_i,
    input  logic [RADDR_W-1:0] id_rs1_i,
    input  logic [RADDR_W-1:0] id_rs2_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               hazard_o,
    output logic               stall_o
);
    logic hit;
    assign hit      = (id_read1_e_i && id_rs1_i == ex_rd_i) || (id_read2_e_i && id_rs2_i == ex_rd_i);
    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard_o = ex_valid_i && ex_memread_i && (|ex_rd_i) && id_valid_i && hit;
    assign stall_o  = hazard_o && !stall_i && !flush_i;
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID->EX pipeline register with load-use bubble insertion, stall/flush and a saturating bubble counter.
//   clk_i, rst_i (async, active-low); p: id_ex_pipe_if.slave carrying ID inputs, stall/flush and EX outputs
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int PERF_W  = PERF_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_pipe_if.slave  p
);
    localparam logic [ALUOP_W-1:0] NOP = ALUOP_W'(ALU_NOP);
    logic               hazard, hold, ld;
    act_e               act;
    logic               valid_q, valid_d;
    logic [5:0]         ctrl_q, ctrl_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [RADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [DATA_W-1:0]  rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0]  imm_q, imm_d, pc_q, pc_d;
    logic [PERF_W-1:0]  cnt_q, cnt_d;

    id_ex_pipe_hazard_detect #(.RADDR_W(RADDR_W)) u_hazard (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q[4]),
        .ex_rd_i      (rd_q),
        .id_valid_i   (p.id_valid_i),
        .id_read1_e_i (p.id_read1_e_i),
        .id_read2_e_i (p.id_read2_e_i),
        .id_rs1_i     (p.id_rs1_i),
        .id_rs2_i     (p.id_rs2_i),
        .stall_i      (p.stall_i),
        .flush_i      (p.flush_i),
        .hazard_o     (hazard),
        .stall_o      (p.stall_o)
    );

    // Flush, bubble and idle all load the same cleared bubble; only the counter tells them apart.
    always_comb begin
        act        = sel_act(p.stall_i, p.flush_i, hazard, p.id_valid_i);
        hold       = act == ACT_HOLD;
        ld         = act == ACT_LOAD;
        valid_d    = hold ? valid_q : ld;
        ctrl_d     = hold ? ctrl_q : ld ? {p.id_branch_i, p.id_memread_i, p.id_memtoreg_i,
                                           p.id_memwrite_i, p.id_alusrc_i, p.id_regwrite_i} : '0;
        aluop_d    = hold ? aluop_q : ld ? p.id_aluop_i : NOP;
        rs1_d      = hold ? rs1_q : ld ? p.id_rs1_i : '0;
        rs2_d      = hold ? rs2_q : ld ? p.id_rs2_i : '0;
        rd_d       = hold ? rd_q : ld ? p.id_rd_i : '0;
        rs1_data_d = hold ? rs1_data_q : ld ? p.id_rs1_data_i : '0;
        rs2_data_d = hold ? rs2_data_q : ld ? p.id_rs2_data_i : '0;
        imm_d      = hold ? imm_q : ld ? p.id_imm_i : '0;
        pc_d       = hold ? pc_q : ld ? p.id_pc_i : '0;
        cnt_d      = (act == ACT_BUBBLE && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            aluop_q    <= NOP;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            aluop_q    <= aluop_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign p.ex_valid_o    = valid_q;
    assign {p.ex_branch_o, p.ex_memread_o, p.ex_memtoreg_o,
            p.ex_memwrite_o, p.ex_alusrc_o, p.ex_regwrite_o} = ctrl_q;
    assign p.ex_aluop_o    = aluop_q;
    assign p.ex_rs1_o      = rs1_q;
    assign p.ex_rs2_o      = rs2_q;
    assign p.ex_rd_o       = rd_q;
    assign p.ex_rs1_data_o = rs1_data_q;
    assign p.ex_rs2_data_o = rs2_data_q;
    assign p.ex_imm_o      = imm_q;
    assign p.ex_pc_o       = pc_q;
    assign p.bubble_cnt_o  = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed self-checking bench for id_ex_pipe (default build plus a PERF_W=4 build).
module tb_id_ex_pipe;
    import id_ex_pipe_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    always #5 clk = ~clk;

    id_ex_pipe_if p ();
    id_ex_pipe_if #(.PERF_W(4)) s ();
    id_ex_pipe u_dut (.clk_i(clk), .rst_i(rst_n), .p(p));
    id_ex_pipe #(.PERF_W(4)) u_sat (.clk_i(clk), .rst_i(rst_n), .p(s));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic mr, input logic [7:0] op, input logic r1e,
                       input logic [4:0] rs1, input logic r2e, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm);
        p.id_valid_i = v; p.id_memread_i = mr; p.id_memtoreg_i = mr; p.id_regwrite_i = v;
        p.id_alusrc_i = v; p.id_branch_i = 1'b0; p.id_memwrite_i = 1'b0; p.id_aluop_i = op;
        p.id_read1_e_i = r1e; p.id_read2_e_i = r2e; p.id_rs1_i = rs1; p.id_rs2_i = rs2; p.id_rd_i = rd;
        p.id_rs1_data_i = 32'hA000_0000 | 32'(rs1); p.id_rs2_data_i = 32'hB000_0000 | 32'(rs2);
        p.id_imm_i = imm; p.id_pc_i = 32'h0000_0100 + 32'(rd);
    endtask

    task automatic drv_s(input logic mr, input logic [4:0] rs1, input logic [4:0] rd);
        s.id_valid_i = 1'b1; s.id_memread_i = mr; s.id_memtoreg_i = mr; s.id_regwrite_i = 1'b1;
        s.id_alusrc_i = 1'b1; s.id_branch_i = 1'b0; s.id_memwrite_i = 1'b0; s.id_aluop_i = ALU_ADD;
        s.id_read1_e_i = 1'b1; s.id_read2_e_i = 1'b0; s.id_rs1_i = rs1; s.id_rs2_i = 5'd0; s.id_rd_i = rd;
        s.id_rs1_data_i = '0; s.id_rs2_data_i = '0; s.id_imm_i = '0; s.id_pc_i = '0;
        s.stall_i = 1'b0; s.flush_i = 1'b0;
    endtask

    task automatic test_plain();
        drv(1, 0, ALU_ADD, 1, 5'd1, 0, 5'd0, 5'd5, 32'd7);
        #1;
        checks++; if (p.stall_o !== 1'b0) begin failures++; $display("FAIL plain_stall_pre got=%b exp=0", p.stall_o); end
        step();
        checks++; if (p.ex_valid_o !== 1'b1) begin failures++; $display("FAIL plain_valid got=%b exp=1", p.ex_valid_o); end
        checks++; if (p.ex_rd_o !== 5'd5) begin failures++; $display("FAIL plain_rd got=%0d exp=5", p.ex_rd_o); end
        checks++; if (p.ex_imm_o !== 32'd7) begin failures++; $display("FAIL plain_imm got=%0d exp=7", p.ex_imm_o); end
        checks++; if (p.ex_aluop_o !== ALU_ADD) begin failures++; $display("FAIL plain_aluop got=%h exp=%h", p.ex_aluop_o, ALU_ADD); end
        checks++; if ({p.ex_regwrite_o, p.ex_alusrc_o, p.ex_memread_o} !== 3'b110) begin failures++; $display("FAIL plain_ctrl got=%b exp=110", {p.ex_regwrite_o, p.ex_alusrc_o, p.ex_memread_o}); end
        checks++; if (p.ex_rs1_data_o !== 32'hA000_0001) begin failures++; $display("FAIL plain_rs1data got=%h exp=a0000001", p.ex_rs1_data_o); end
        checks++; if (p.ex_pc_o !== 32'h105) begin failures++; $display("FAIL plain_pc got=%h exp=105", p.ex_pc_o); end
        checks++; if (p.stall_o !== 1'b0) begin failures++; $display("FAIL plain_stall_post got=%b exp=0", p.stall_o); end
        drv(0, 0, ALU_NOP, 0, 5'd0, 0, 5'd0, 5'd0, 32'd0);
        step();
        checks++; if (p.ex_valid_o !== 1'b0 || p.ex_rd_o !== 5'd0) begin failures++; $display("FAIL idle_bubble got=%b/%0d exp=0/0", p.ex_valid_o, p.ex_rd_o); end
        checks++; if (p.bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL idle_cnt got=%0d exp=%0d", p.bubble_cnt_o, exp_cnt); end
    endtask

    task automatic test_load_use();
        drv(1, 1, ALU_ADD, 1, 5'd2, 0, 5'd0, 5'd6, 32'd0);
        step();
        drv(1, 0, ALU_OR, 1, 5'd6, 0, 5'd0, 5'd7, 32'd1);
        #1;
        checks++; if (p.stall_o !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", p.stall_o); end
        step();
        exp_cnt++;
        checks++; if (p.ex_valid_o !== 1'b0 || p.ex_aluop_o !== ALU_NOP || p.ex_regwrite_o !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b/%h/%b exp=0/00/0", p.ex_valid_o, p.ex_aluop_o, p.ex_regwrite_o); end
        checks++; if (p.bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL lu_cnt got=%0d exp=%0d", p.bubble_cnt_o, exp_cnt); end
        checks++; if (p.stall_o !== 1'b0) begin failures++; $display("FAIL lu_stall_drop got=%b exp=0", p.stall_o); end
        step();
        checks++; if (p.ex_valid_o !== 1'b1 || p.ex_rd_o !== 5'd7 || p.ex_aluop_o !== ALU_OR) begin failures++; $display("FAIL lu_ori got=%b/%0d/%h exp=1/7/02", p.ex_valid_o, p.ex_rd_o, p.ex_aluop_o); end
        checks++; if (p.bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL lu_cnt_after got=%0d exp=%0d", p.bubble_cnt_o, exp_cnt); end
        drv(1, 1, ALU_ADD, 1, 5'd2, 0, 5'd0, 5'd9, 32'd0);
        step();
        drv(1, 0, ALU_ADD, 0, 5'd0, 1, 5'd9, 5'd10, 32'd0);
        #1;
        checks++; if (p.stall_o !== 1'b1) begin failures++; $display("FAIL lu_rs2_stall got=%b exp=1", p.stall_o); end
        step();
        exp_cnt++;
        step();
    endtask

    task automatic test_no_hazard();
        drv(1, 1, ALU_ADD, 1, 5'd2, 0, 5'd0, 5'd0, 32'd0);
        step();
        drv(1, 0, ALU_OR, 1, 5'd0, 1, 5'd0, 5'd7, 32'd1);
        #1;
        checks++; if (p.stall_o !== 1'b0) begin failures++; $display("FAIL nh_rd0 got=%b exp=0", p.stall_o); end
        drv(1, 1, ALU_ADD, 1, 5'd2, 0, 5'd0, 5'd6, 32'd0);
        step();
        drv(1, 0, ALU_OR, 0, 5'd6, 0, 5'd6, 5'd7, 32'd1);
        #1;
        checks++; if (p.stall_o !== 1'b0) begin failures++; $display("FAIL nh_re0 got=%b exp=0", p.stall_o); end
        step();
        checks++; if (p.ex_valid_o !== 1'b1 || p.ex_rd_o !== 5'd7) begin failures++; $display("FAIL nh_re0_load got=%b/%0d exp=1/7", p.ex_valid_o, p.ex_rd_o); end
        checks++; if (p.bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL nh_cnt got=%0d exp=%0d", p.bubble_cnt_o, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        drv(1, 1, ALU_ADD, 1, 5'd2, 0, 5'd0, 5'd6, 32'd0);
        step();
        drv(1, 0, ALU_OR, 1, 5'd6, 0, 5'd0, 5'd7, 32'd1);
        step();
        exp_cnt++;
        step();
        drv(1, 0, ALU_ADD, 0, 5'd0, 1, 5'd6, 5'd8, 32'd2);
        #1;
        checks++; if (p.stall_o !== 1'b0) begin failures++; $display("FAIL b2b_second_stall got=%b exp=0", p.stall_o); end
        step();
        checks++; if (p.ex_valid_o !== 1'b1 || p.ex_rd_o !== 5'd8) begin failures++; $display("FAIL b2b_second got=%b/%0d exp=1/8", p.ex_valid_o, p.ex_rd_o); end
        checks++; if (p.bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", p.bubble_cnt_o, exp_cnt); end
    endtask

    task automatic test_stall();
        drv(1, 1, ALU_ADD, 1, 5'd2, 0, 5'd0, 5'd6, 32'd3);
        step();
        drv(1, 0, ALU_OR, 1, 5'd6, 0, 5'd0, 5'd7, 32'd1);
        p.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (p.stall_o !== 1'b0) begin failures++; $display("FAIL st_stall_o[%0d] got=%b exp=0", i, p.stall_o); end
            step();
            checks++; if (p.ex_valid_o !== 1'b1 || p.ex_rd_o !== 5'd6 || p.ex_memread_o !== 1'b1 || p.ex_imm_o !== 32'd3) begin failures++; $display("FAIL st_hold[%0d] got=%b/%0d/%b/%0d exp=1/6/1/3", i, p.ex_valid_o, p.ex_rd_o, p.ex_memread_o, p.ex_imm_o); end
            checks++; if (p.bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL st_cnt[%0d] got=%0d exp=%0d", i, p.bubble_cnt_o, exp_cnt); end
        end
        p.stall_i = 1'b0;
        #1;
        checks++; if (p.stall_o !== 1'b1) begin failures++; $display("FAIL st_release_stall got=%b exp=1", p.stall_o); end
        step();
        exp_cnt++;
        checks++; if (p.ex_valid_o !== 1'b0 || p.bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL st_release got=%b/%0d exp=0/%0d", p.ex_valid_o, p.bubble_cnt_o, exp_cnt); end
        step();
    endtask

    task automatic test_flush();
        drv(1, 1, ALU_ADD, 1, 5'd2, 0, 5'd0, 5'd6, 32'd0);
        step();
        drv(1, 0, ALU_OR, 1, 5'd6, 0, 5'd0, 5'd7, 32'd1);
        p.flush_i = 1'b1;
        #1;
        checks++; if (p.stall_o !== 1'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", p.stall_o); end
        step();
        p.flush_i = 1'b0;
        checks++; if (p.ex_valid_o !== 1'b0 || p.ex_rd_o !== 5'd0 || p.ex_memread_o !== 1'b0) begin failures++; $display("FAIL fl_bubble got=%b/%0d/%b exp=0/0/0", p.ex_valid_o, p.ex_rd_o, p.ex_memread_o); end
        checks++; if (p.bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL fl_cnt got=%0d exp=%0d", p.bubble_cnt_o, exp_cnt); end
        drv(0, 0, ALU_NOP, 0, 5'd0, 0, 5'd0, 5'd0, 32'd0);
        step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drv_s(1'b1, 5'd1, 5'd6);
            step();
            drv_s(1'b0, 5'd6, 5'd7);
            step();
            if (i == 13) begin
                checks++; if (s.bubble_cnt_o !== 4'd14) begin failures++; $display("FAIL sat_cnt14 got=%0d exp=14", s.bubble_cnt_o); end
            end
        end
        checks++; if (s.bubble_cnt_o !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", s.bubble_cnt_o); end
        checks++; if (p.bubble_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL sat_main_cnt got=%0d exp=%0d", p.bubble_cnt_o, exp_cnt); end
    endtask

    task automatic test_reset();
        drv(1, 0, ALU_ADD, 1, 5'd1, 0, 5'd0, 5'd5, 32'd7);
        step();
        checks++; if (p.ex_valid_o !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", p.ex_valid_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (p.ex_valid_o !== 1'b0 || p.ex_rd_o !== 5'd0 || p.ex_imm_o !== 32'd0 || p.ex_pc_o !== 32'd0) begin failures++; $display("FAIL rst_ex got=%b/%0d/%0d/%h exp=0/0/0/0", p.ex_valid_o, p.ex_rd_o, p.ex_imm_o, p.ex_pc_o); end
        checks++; if (p.ex_aluop_o !== ALU_NOP || p.ex_regwrite_o !== 1'b0 || p.ex_alusrc_o !== 1'b0) begin failures++; $display("FAIL rst_ctrl got=%h/%b/%b exp=00/0/0", p.ex_aluop_o, p.ex_regwrite_o, p.ex_alusrc_o); end
        checks++; if (p.bubble_cnt_o !== 16'd0 || s.bubble_cnt_o !== 4'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", p.bubble_cnt_o, s.bubble_cnt_o); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        drv(0, 0, ALU_NOP, 0, 5'd0, 0, 5'd0, 5'd0, 32'd0);
        p.stall_i = 1'b0;
        p.flush_i = 1'b0;
        drv_s(1'b0, 5'd0, 5'd0);
        s.id_valid_i = 1'b0;
        step();
        checks++; if (p.ex_valid_o !== 1'b0 || p.ex_aluop_o !== ALU_NOP || p.bubble_cnt_o !== 16'd0) begin failures++; $display("FAIL init_reset got=%b/%h/%0d exp=0/00/0", p.ex_valid_o, p.ex_aluop_o, p.bubble_cnt_o); end
        rst_n = 1'b1;
        step();
        test_plain();
        test_load_use();
        test_no_hazard();
        test_back_to_back();
        test_stall();
        test_flush();
        test_saturation();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
